// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake: valid/bus from the memory stage, allowin back from write-back.
interface wb_stage_if #(
  parameter int BUS_WD = 175
);
  logic              ms_to_ws_valid;
  logic [BUS_WD-1:0] ms_to_ws_bus;
  logic              ws_allowin;

  modport master (output ms_to_ws_valid, output ms_to_ws_bus, input  ws_allowin);
  modport slave  (input  ms_to_ws_valid, input  ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: commits to the register file, arbitrates exceptions/ERET/TLB refetch
// and holds the minimal CP0 state (Status, Cause, EPC, BadVAddr).
module wb_stage #(
  parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
  parameter logic [31:0] REFILL_ENTRY = 32'hbfc00200,
  parameter int          BUS_WD       = 175
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   ms,
  output logic        ws_reflush,
  output logic        refetch,
  output logic [31:0] ws_flush_pc,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef struct packed {
    logic        exe_refill;
    logic        if_refill;
    logic        tlbwi;
    logic        tlbp;
    logic        tlbr;
    logic        bd;
    logic [31:0] mem_addr;
    logic        mem_ex;
    logic [4:0]  mem_excode;
    logic        exe_ex;
    logic [4:0]  exe_excode;
    logic        id_ex;
    logic [4:0]  id_excode;
    logic        if_ex;
    logic [4:0]  if_excode;
    logic [4:0]  rd;
    logic [31:0] rt_value;
    logic        mfc0;
    logic        mtc0;
    logic        eret;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } wb_bus_t;

  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
  localparam logic [31:0] STATUS_MASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_MASK  = 32'h0000_0300;

  logic        r_ws_valid;
  wb_bus_t     r_bus;
  logic [31:0] r_status, r_cause, r_epc, r_badvaddr;

  logic        w_ready_go, w_ex, w_eret, w_refetch, w_refill, w_mtc0, w_badv_hit;
  logic [4:0]  w_excode;
  logic [31:0] w_cp0_rdata, w_pc_plus4;
  logic        w_unused;

  assign w_ready_go    = 1'b1;
  assign ms.ws_allowin = !r_ws_valid || w_ready_go;
  assign w_unused      = r_bus.tlbp;

  // Fixed priority: the oldest faulting stage (IF) reports first.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_excode = r_bus.mem_excode;
    if (r_bus.if_ex)       w_excode = r_bus.if_excode;
    else if (r_bus.id_ex)  w_excode = r_bus.id_excode;
    else if (r_bus.exe_ex) w_excode = r_bus.exe_excode;
  end

  assign w_ex       = r_ws_valid && (r_bus.if_ex || r_bus.id_ex || r_bus.exe_ex || r_bus.mem_ex);
  assign w_eret     = r_ws_valid && r_bus.eret;
  assign w_refetch  = r_ws_valid && !w_ex && (r_bus.tlbwi || r_bus.tlbr);
  assign w_refill   = (r_bus.if_refill || r_bus.exe_refill) && !r_status[1];
  assign w_mtc0     = r_ws_valid && r_bus.mtc0 && !w_ex;
  assign w_badv_hit = (w_excode >= 5'd1) && (w_excode <= 5'd5);
  assign w_pc_plus4 = r_bus.pc + 32'd4;

  assign ws_reflush = w_ex || w_eret;
  assign refetch    = w_refetch;

  always_comb begin
    ws_flush_pc = 32'h0;
    if (w_ex && w_refill) ws_flush_pc = REFILL_ENTRY;
    else if (w_ex)        ws_flush_pc = EX_ENTRY;
    else if (w_eret)      ws_flush_pc = r_epc;
    else if (w_refetch)   ws_flush_pc = w_pc_plus4;
  end

  always_comb begin
    w_cp0_rdata = 32'h0;
    case (r_bus.rd)
      5'd8:    w_cp0_rdata = r_badvaddr;
      5'd12:   w_cp0_rdata = r_status;
      5'd13:   w_cp0_rdata = r_cause;
      5'd14:   w_cp0_rdata = r_epc;
      default: w_cp0_rdata = 32'h0;
    endcase
  end

  assign rf_we    = r_bus.gr_we & {4{r_ws_valid && !w_ex}};
  assign rf_waddr = r_bus.dest;
  assign rf_wdata = r_bus.mfc0 ? w_cp0_rdata : r_bus.result;

  assign debug_wb_pc       = r_bus.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // NOTE: sequential state uses non-blocking assignments only; the bus register is reset too
  // because the debug port must read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (ws_reflush || w_refetch) r_ws_valid <= 1'b0;
      else if (ms.ws_allowin)      r_ws_valid <= ms.ms_to_ws_valid;
      if (ms.ms_to_ws_valid && ms.ws_allowin) r_bus <= wb_bus_t'(ms.ms_to_ws_bus);
    end
  end

  // Exception update is last so it overrides any mtc0 issued by the same instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status   <= STATUS_RST;
      r_cause    <= 32'h0;
      r_epc      <= 32'h0;
      r_badvaddr <= 32'h0;
    end else begin
      if (w_mtc0) begin
        case (r_bus.rd)
          5'd12:   r_status <= (r_status & ~STATUS_MASK) | (r_bus.rt_value & STATUS_MASK);
          5'd13:   r_cause  <= (r_cause & ~CAUSE_MASK) | (r_bus.rt_value & CAUSE_MASK);
          5'd14:   r_epc    <= r_bus.rt_value;
          default: ;
        endcase
      end
      if (w_eret && !w_ex) r_status[1] <= 1'b0;
      if (w_ex) begin
        r_status[1]   <= 1'b1;
        r_cause[6:2]  <= w_excode;
        r_cause[31]   <= r_bus.bd;
        if (!r_status[1]) r_epc <= r_bus.bd ? r_bus.pc - 32'd4 : r_bus.pc;
        if (w_badv_hit)   r_badvaddr <= r_bus.if_ex ? r_bus.pc : r_bus.mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; CP0 state is observed through mfc0 commits.
module tb_wb_stage;

  typedef struct packed {
    logic        exe_refill;
    logic        if_refill;
    logic        tlbwi;
    logic        tlbp;
    logic        tlbr;
    logic        bd;
    logic [31:0] mem_addr;
    logic        mem_ex;
    logic [4:0]  mem_excode;
    logic        exe_ex;
    logic [4:0]  exe_excode;
    logic        id_ex;
    logic [4:0]  id_excode;
    logic        if_ex;
    logic [4:0]  if_excode;
    logic [4:0]  rd;
    logic [31:0] rt_value;
    logic        mfc0;
    logic        mtc0;
    logic        eret;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } bus_t;

  logic clk = 1'b0;
  logic reset;
  logic        ws_reflush, refetch;
  logic [31:0] ws_flush_pc, rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  rf_we, debug_wb_rf_wen;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;

  int n_checks = 0;
  int n_fail   = 0;
  bus_t b;
  logic [31:0] v;

  always #5 clk = ~clk;

  wb_stage_if #(.BUS_WD(175)) ms_if ();

  wb_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ms               (ms_if),
    .ws_reflush       (ws_reflush),
    .refetch          (refetch),
    .ws_flush_pc      (ws_flush_pc),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Present one instruction; on return it sits in WB and outputs are settled.
  task automatic drive(input bus_t x);
    @(negedge clk);
    ms_if.ms_to_ws_valid = 1'b1;
    ms_if.ms_to_ws_bus   = x;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    ms_if.ms_to_ws_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic read_cp0(input logic [4:0] rd, output logic [31:0] val);
    bus_t x;
    x = '0;
    x.mfc0 = 1'b1; x.rd = rd; x.dest = 5'd3; x.gr_we = 4'hf; x.pc = 32'hbfc0_0f00;
    drive(x);
    val = rf_wdata;
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ms_if.ms_to_ws_valid = 1'b0;
    ms_if.ms_to_ws_bus   = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ms_if.ws_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %h want 1", ms_if.ws_allowin); end
    n_checks++; if (rf_we !== 4'h0) begin n_fail++; $display("FAIL reset_rf_we got %h want 0", rf_we); end
    n_checks++; if ({ws_reflush, refetch} !== 2'b00) begin n_fail++; $display("FAIL reset_flush got %b want 00", {ws_reflush, refetch}); end
    n_checks++; if (ws_flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc got %h want 0", ws_flush_pc); end
    n_checks++; if (debug_wb_pc !== 32'h0) begin n_fail++; $display("FAIL reset_debug_pc got %h want 0", debug_wb_pc); end
    @(negedge clk);
    reset = 1'b0;
    read_cp0(5'd12, v);
    n_checks++; if (v !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got %h want 00400000", v); end
  endtask

  task automatic test_plain_commit();
    b = '0;
    b.pc = 32'hbfc0_0010; b.dest = 5'd5; b.gr_we = 4'hf; b.result = 32'h1234;
    drive(b);
    n_checks++; if (rf_we !== 4'hf) begin n_fail++; $display("FAIL plain_rf_we got %h want f", rf_we); end
    n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL plain_waddr got %0d want 5", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL plain_wdata got %h want 1234", rf_wdata); end
    n_checks++; if (debug_wb_pc !== 32'hbfc0_0010) begin n_fail++; $display("FAIL plain_debug_pc got %h want bfc00010", debug_wb_pc); end
    n_checks++; if ({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== {4'hf, 5'd5, 32'h1234})
      begin n_fail++; $display("FAIL plain_debug_rf got %h/%0d/%h want f/5/1234", debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata); end
    n_checks++; if (ws_reflush !== 1'b0) begin n_fail++; $display("FAIL plain_reflush got %b want 0", ws_reflush); end
    idle();
    n_checks++; if (dut.r_ws_valid !== 1'b0) begin n_fail++; $display("FAIL plain_valid_drop got %b want 0", dut.r_ws_valid); end
    n_checks++; if (rf_we !== 4'h0) begin n_fail++; $display("FAIL plain_idle_we got %h want 0", rf_we); end
  endtask

  task automatic test_syscall();
    b = '0;
    b.id_ex = 1'b1; b.id_excode = 5'd8; b.pc = 32'hbfc0_0100; b.gr_we = 4'hf; b.dest = 5'd7;
    drive(b);
    n_checks++; if (ws_reflush !== 1'b1) begin n_fail++; $display("FAIL sys_reflush got %b want 1", ws_reflush); end
    n_checks++; if (ws_flush_pc !== 32'hbfc0_0380) begin n_fail++; $display("FAIL sys_flush_pc got %h want bfc00380", ws_flush_pc); end
    n_checks++; if (rf_we !== 4'h0) begin n_fail++; $display("FAIL sys_rf_we got %h want 0", rf_we); end
    n_checks++; if (refetch !== 1'b0) begin n_fail++; $display("FAIL sys_refetch got %b want 0", refetch); end
    idle();
    n_checks++; if (dut.r_ws_valid !== 1'b0) begin n_fail++; $display("FAIL sys_valid got %b want 0", dut.r_ws_valid); end
    read_cp0(5'd14, v);
    n_checks++; if (v !== 32'hbfc0_0100) begin n_fail++; $display("FAIL sys_epc got %h want bfc00100", v); end
    read_cp0(5'd13, v);
    n_checks++; if (v !== 32'h0000_0020) begin n_fail++; $display("FAIL sys_cause got %h want 00000020", v); end
    read_cp0(5'd12, v);
    n_checks++; if (v !== 32'h0040_0002) begin n_fail++; $display("FAIL sys_status got %h want 00400002", v); end
  endtask

  task automatic test_delay_slot_adel();
    // Masked mtc0 writes; Status write also clears EXL so EPC can update.
    b = '0; b.mtc0 = 1'b1; b.rd = 5'd12; b.rt_value = 32'hffff_fffc; b.pc = 32'hbfc0_0200;
    drive(b); idle();
    read_cp0(5'd12, v);
    n_checks++; if (v !== 32'h0040_ff00) begin n_fail++; $display("FAIL mtc0_status_mask got %h want 0040ff00", v); end
    b = '0; b.mtc0 = 1'b1; b.rd = 5'd13; b.rt_value = 32'hffff_ffff; b.pc = 32'hbfc0_0204;
    drive(b); idle();
    read_cp0(5'd13, v);
    n_checks++; if (v !== 32'h0000_0320) begin n_fail++; $display("FAIL mtc0_cause_mask got %h want 00000320", v); end
    b = '0; b.mtc0 = 1'b1; b.rd = 5'd8; b.rt_value = 32'h5555_5555; b.pc = 32'hbfc0_0208;
    drive(b); idle();
    read_cp0(5'd8, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL mtc0_badv_ro got %h want 0", v); end

    b = '0;
    b.if_ex = 1'b1; b.if_excode = 5'd4; b.exe_ex = 1'b1; b.exe_excode = 5'd12;
    b.pc = 32'h8000_0002; b.bd = 1'b1; b.mem_addr = 32'h1234_5678;
    drive(b);
    n_checks++; if ({ws_reflush, ws_flush_pc} !== {1'b1, 32'hbfc0_0380})
      begin n_fail++; $display("FAIL adel_flush got %b/%h want 1/bfc00380", ws_reflush, ws_flush_pc); end
    idle();
    read_cp0(5'd14, v);
    n_checks++; if (v !== 32'h7fff_fffe) begin n_fail++; $display("FAIL adel_epc got %h want 7ffffffe", v); end
    read_cp0(5'd13, v);
    n_checks++; if (v !== 32'h8000_0310) begin n_fail++; $display("FAIL adel_cause got %h want 80000310", v); end
    read_cp0(5'd8, v);
    n_checks++; if (v !== 32'h8000_0002) begin n_fail++; $display("FAIL adel_badv got %h want 80000002", v); end
    read_cp0(5'd12, v);
    n_checks++; if (v !== 32'h0040_ff02) begin n_fail++; $display("FAIL adel_status got %h want 0040ff02", v); end
  endtask

  task automatic test_mtc0_eret();
    b = '0; b.mtc0 = 1'b1; b.rd = 5'd14; b.rt_value = 32'hbfc0_0500; b.pc = 32'hbfc0_0300;
    drive(b);
    n_checks++; if ({rf_we, ws_reflush} !== 5'b0) begin n_fail++; $display("FAIL mtc0_side got %h/%b want 0/0", rf_we, ws_reflush); end
    b = '0; b.eret = 1'b1; b.pc = 32'hbfc0_0304;
    drive(b);
    n_checks++; if ({ws_reflush, ws_flush_pc} !== {1'b1, 32'hbfc0_0500})
      begin n_fail++; $display("FAIL eret_flush got %b/%h want 1/bfc00500", ws_reflush, ws_flush_pc); end
    idle();
    read_cp0(5'd12, v);
    n_checks++; if (v !== 32'h0040_ff00) begin n_fail++; $display("FAIL eret_status got %h want 0040ff00", v); end
    b = '0; b.mfc0 = 1'b1; b.rd = 5'd14; b.dest = 5'd3; b.gr_we = 4'hf; b.pc = 32'hbfc0_0500;
    drive(b);
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {4'hf, 5'd3, 32'hbfc0_0500})
      begin n_fail++; $display("FAIL mfc0_epc got %h/%0d/%h want f/3/bfc00500", rf_we, rf_waddr, rf_wdata); end
    idle();
    // Exception and mtc0 on the same instruction: mtc0 is dropped.
    b = '0; b.mtc0 = 1'b1; b.rd = 5'd14; b.rt_value = 32'hdead_beef;
    b.id_ex = 1'b1; b.id_excode = 5'd10; b.pc = 32'h8000_1000;
    drive(b); idle();
    read_cp0(5'd14, v);
    n_checks++; if (v !== 32'h8000_1000) begin n_fail++; $display("FAIL ex_mtc0_epc got %h want 80001000", v); end
    b = '0; b.eret = 1'b1; b.pc = 32'h8000_2000;
    drive(b); idle();
  endtask

  task automatic test_tlb_refill_refetch();
    b = '0; b.exe_refill = 1'b1; b.exe_ex = 1'b1; b.exe_excode = 5'd2;
    b.pc = 32'h0040_0000; b.mem_addr = 32'h0000_1ffc;
    drive(b);
    n_checks++; if ({ws_reflush, ws_flush_pc} !== {1'b1, 32'hbfc0_0200})
      begin n_fail++; $display("FAIL refill_flush got %b/%h want 1/bfc00200", ws_reflush, ws_flush_pc); end
    idle();
    read_cp0(5'd8, v);
    n_checks++; if (v !== 32'h0000_1ffc) begin n_fail++; $display("FAIL refill_badv got %h want 00001ffc", v); end
    b.pc = 32'h0050_0000;
    drive(b);
    n_checks++; if (ws_flush_pc !== 32'hbfc0_0380) begin n_fail++; $display("FAIL refill_exl_pc got %h want bfc00380", ws_flush_pc); end
    idle();
    read_cp0(5'd14, v);
    n_checks++; if (v !== 32'h0040_0000) begin n_fail++; $display("FAIL refill_epc_hold got %h want 00400000", v); end

    b = '0; b.tlbwi = 1'b1; b.pc = 32'h0000_0100;
    drive(b);
    n_checks++; if ({refetch, ws_reflush, ws_flush_pc} !== {2'b10, 32'h0000_0104})
      begin n_fail++; $display("FAIL tlbwi_refetch got %b%b/%h want 10/00000104", refetch, ws_reflush, ws_flush_pc); end
    b = '0; b.gr_we = 4'hf; b.dest = 5'd9; b.result = 32'h99; b.pc = 32'h0000_0104;
    drive(b);
    n_checks++; if (rf_we !== 4'h0) begin n_fail++; $display("FAIL refetch_kill got %h want 0", rf_we); end
    idle();
  endtask

  task automatic test_reset_mid_exception();
    b = '0; b.id_ex = 1'b1; b.id_excode = 5'd8; b.pc = 32'hbfc0_0700; b.gr_we = 4'hf;
    drive(b);
    @(negedge clk);
    reset = 1'b1;
    ms_if.ms_to_ws_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if ({dut.r_ws_valid, rf_we, ws_reflush} !== 6'b0)
      begin n_fail++; $display("FAIL rst_ex_outs got %b/%h/%b want 0/0/0", dut.r_ws_valid, rf_we, ws_reflush); end
    @(negedge clk);
    reset = 1'b0;
    read_cp0(5'd12, v);
    n_checks++; if (v !== 32'h0040_0000) begin n_fail++; $display("FAIL rst_ex_status got %h want 00400000", v); end
    read_cp0(5'd14, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_ex_epc got %h want 0", v); end
    read_cp0(5'd13, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_ex_cause got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_plain_commit();
    test_syscall();
    test_delay_slot_adel();
    test_mtc0_eret();
    test_tlb_refill_refetch();
    test_reset_mid_exception();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Final (write-back) pipeline stage of the 5-stage MIPS core. It consumes the MEM-to-WB bus and commits results to the register file with per-byte enables, so partial LWL/LWR writes commit correctly. It arbitrates exceptions, ERET and TLB-refetch at commit, and owns the minimal CP0 state (Status, Cause, EPC, BadVAddr). It issues the pipeline flush and the redirect PC, and drives the debug trace port.

Parameters:
EX_ENTRY, 32'hbfc00380, general exception vector
REFILL_ENTRY, 32'hbfc00200, TLB-refill vector when Status.EXL=0
BUS_WD, 175, width of ms_to_ws_bus

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ms_to_ws_valid  in  1  MEM stage holds a valid instruction
ms_to_ws_bus  in  175  [174]exe_refill [173]if_refill [172]tlbwi [171]tlbp [170]tlbr [169]bd [168:137]mem_addr [136]mem_ex [135:131]mem_excode [130]exe_ex [129:125]exe_excode [124]id_ex [123:119]id_excode [118]if_ex [117:113]if_excode [112:108]rd [107:76]rt_value [75]mfc0 [74]mtc0 [73]eret [72:69]gr_we [68:64]dest [63:32]result [31:0]pc
ws_allowin  out  1  WB can accept
ws_reflush  out  1  flush all younger stages this cycle
refetch  out  1  TLB-op refetch flush this cycle
ws_flush_pc  out  32  redirect target, valid while ws_reflush|refetch
rf_we  out  4  register-file byte write enables
rf_waddr  out  5  destination register
rf_wdata  out  32  write data
debug_wb_pc  out  32  committed PC
debug_wb_rf_wen  out  4  equals rf_we
debug_wb_rf_wnum  out  5  equals rf_waddr
debug_wb_rf_wdata  out  32  equals rf_wdata

Behaviour:
- Register stage: ws_valid, bus_r.
  - reset → ws_valid=0, bus_r=0.
  - ws_reflush|refetch → ws_valid=0 next cycle.
  - Otherwise, when ws_allowin: ws_valid<=ms_to_ws_valid.
  - bus_r loads on ms_to_ws_valid&ws_allowin.
  - ws_ready_go=1; ws_allowin = !ws_valid | ws_ready_go (always 1).
- Exception select, fixed priority if > id > exe > mem.
  - ex = ws_valid & (if_ex|id_ex|exe_ex|mem_ex).
  - excode is taken from the highest-priority flagged stage.
- ws_reflush = ex | (ws_valid & eret). Combinational, one cycle.
- refetch = ws_valid & ~ex & (tlbwi|tlbr). Flush target is pc+4.
- ws_flush_pc priority:
  - ex & (if_refill|exe_refill) & ~EXL → REFILL_ENTRY
  - ex → EX_ENTRY
  - eret → EPC
  - refetch → pc+4
  - else 0
- rf_we = gr_we & {4{ws_valid & ~ex}}. rf_waddr = dest.
- rf_wdata = mfc0 ? CP0[rd] : result.
- Writes are masked by ex; eret, mtc0 and tlb ops carry gr_we=0 upstream.
- CP0 state. Reset values: Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, BadVAddr=0.
  - mfc0 readable rd: 8 BadVAddr, 12 Status, 13 Cause, 14 EPC; other rd read 0.
  - On ex:
    - Status.EXL(bit1)<=1.
    - Cause.ExcCode[6:2]<=excode; Cause.BD[31]<=bd.
    - If EXL was 0: EPC<=bd ? pc-4 : pc. If EXL was 1, EPC is held.
  - BadVAddr on ex, excode ∈ {4 AdEL, 5 AdES, 1/2/3 TLB}: if_ex → pc, else → mem_addr.
  - On eret (no ex): Status.EXL<=0.
  - mtc0 (ws_valid, no ex):
    - Status writes bits 15:8 and 1:0 only.
    - Cause writes only bits 9:8.
    - EPC writes all 32 bits.
    - BadVAddr is read-only.
  - Simultaneous ex and mtc0: the exception update wins, and the mtc0 write is dropped.
- Debug outputs mirror the rf_* ports and pc. Reset value of all outputs is 0, except that ws_allowin=1.

Test Plan:
1. Plain commit. Bus: pc=0xbfc00010, dest=5, gr_we=4'hf, result=0x1234 → same cycle rf_we=f, rf_waddr=5, rf_wdata=0x1234, debug_wb_pc=0xbfc00010. Next: ws_valid=0 once ms_to_ws_valid drops.
2. Syscall. id_ex=1, id_excode=8, pc=0xbfc00100, bd=0 → ws_reflush=1, ws_flush_pc=0xbfc00380, rf_we=0. Next cycle: EPC=0xbfc00100, Cause[6:2]=8, Status.EXL=1, ws_valid=0.
3. Delay-slot AdEL. if_ex=1, excode=4, pc=0x80000002, bd=1 → EPC=0x7ffffffe, Cause.BD=1, BadVAddr=0x80000002. Same cycle, exe_ex=1 must lose to if_ex.
4. mtc0/eret. mtc0 rd=14, rt_value=0xbfc00500, then eret → ws_reflush=1, ws_flush_pc=0xbfc00500. Next cycle: Status.EXL=0. Then mfc0 rd=14, dest=3 → rf_wdata=0xbfc00500.
5. TLB refill/refetch. exe_refill=1, exe_ex=1, excode=2, EXL=0 → ws_flush_pc=0xbfc00200. tlbwi at pc=0x100 (no ex) → refetch=1, ws_flush_pc=0x104, ws_reflush=0.
6. Reset mid-exception. Assert reset in the same cycle as ex → next cycle Status=0x00400000, EPC=0, ws_valid=0, rf_we=0.
